// File: rtl/axi_cdc_dst_gray_pkg.sv
// Shared AXI channel and request/response typedefs for the gray-pointer CDC
// destination half. Payloads are kept to 8 bits so the slice stays small; the
// top module takes every type as a parameter, so wider channels drop in
// without touching the logic.
package axi_cdc_dst_gray_pkg;

    typedef struct packed {
        logic [7:0] addr;
    } aw_chan_t;

    typedef struct packed {
        logic [7:0] data;
    } w_chan_t;

    typedef struct packed {
        logic [7:0] id;
    } b_chan_t;

    typedef struct packed {
        logic [7:0] addr;
    } ar_chan_t;

    typedef struct packed {
        logic [7:0] data;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } axi_resp_t;

endpackage

// File: rtl/axi_cdc_gray_ptr_sync.sv
// Pointer helper for one CDC channel: brings the remote gray pointer into the
// local clock domain through a SyncStages-deep flop chain, and converts a
// local binary pointer to gray.
//   clk, rst_n   : local clock, async active-low reset
//   ptr_async    : gray pointer owned by the other clock domain
//   ptr_bin      : local binary pointer to convert
//   ptr_synced   : ptr_async after SyncStages local flops
//   ptr_gray     : gray encoding of ptr_bin (combinational)
module axi_cdc_gray_ptr_sync
    import axi_cdc_dst_gray_pkg::*;
#(
    parameter int unsigned PtrWidth   = 2,
    parameter int unsigned SyncStages = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PtrWidth-1:0] ptr_async,
    input  logic [PtrWidth-1:0] ptr_bin,
    output logic [PtrWidth-1:0] ptr_synced,
    output logic [PtrWidth-1:0] ptr_gray
);

    logic [PtrWidth-1:0] sync_q [SyncStages];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SyncStages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= ptr_async;
            for (int unsigned i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign ptr_synced = sync_q[SyncStages-1];
    assign ptr_gray   = ptr_bin ^ (ptr_bin >> 1);

endmodule

// File: rtl/axi_cdc_dst_gray.sv
// Destination half of a gray-pointer AXI clock-domain crossing.
// aw/w/ar arrive through source-owned FIFO storage: this side synchronizes the
// source write pointer, pops into the local AXI master port and returns a gray
// read pointer. b/r are captured locally into owned storage and announced to
// the source through a gray write pointer.
//   dst_clk_i, dst_rst_ni            : destination clock, async active-low reset
//   dst_req_o / dst_resp_i           : local AXI master request / response
//   async_data_slave_{aw,w,ar}_*     : data_i, wptr_i in; rptr_o out
//   async_data_slave_{b,r}_*         : data_o, wptr_o out; rptr_i in
module axi_cdc_dst_gray
    import axi_cdc_dst_gray_pkg::*;
#(
    parameter int unsigned LogDepth   = 1,
    parameter int unsigned SyncStages = 2,
    parameter type aw_chan_t  = axi_cdc_dst_gray_pkg::aw_chan_t,
    parameter type w_chan_t   = axi_cdc_dst_gray_pkg::w_chan_t,
    parameter type b_chan_t   = axi_cdc_dst_gray_pkg::b_chan_t,
    parameter type ar_chan_t  = axi_cdc_dst_gray_pkg::ar_chan_t,
    parameter type r_chan_t   = axi_cdc_dst_gray_pkg::r_chan_t,
    parameter type axi_req_t  = axi_cdc_dst_gray_pkg::axi_req_t,
    parameter type axi_resp_t = axi_cdc_dst_gray_pkg::axi_resp_t,
    localparam int unsigned Depth = 2**LogDepth,
    localparam int unsigned PtrW  = LogDepth + 1
) (
    input  logic              dst_clk_i,
    input  logic              dst_rst_ni,
    output axi_req_t          dst_req_o,
    input  axi_resp_t         dst_resp_i,
    input  aw_chan_t          async_data_slave_aw_data_i [Depth],
    input  logic [PtrW-1:0]   async_data_slave_aw_wptr_i,
    output logic [PtrW-1:0]   async_data_slave_aw_rptr_o,
    input  w_chan_t           async_data_slave_w_data_i [Depth],
    input  logic [PtrW-1:0]   async_data_slave_w_wptr_i,
    output logic [PtrW-1:0]   async_data_slave_w_rptr_o,
    input  ar_chan_t          async_data_slave_ar_data_i [Depth],
    input  logic [PtrW-1:0]   async_data_slave_ar_wptr_i,
    output logic [PtrW-1:0]   async_data_slave_ar_rptr_o,
    output b_chan_t           async_data_slave_b_data_o [Depth],
    output logic [PtrW-1:0]   async_data_slave_b_wptr_o,
    input  logic [PtrW-1:0]   async_data_slave_b_rptr_i,
    output r_chan_t           async_data_slave_r_data_o [Depth],
    output logic [PtrW-1:0]   async_data_slave_r_wptr_o,
    input  logic [PtrW-1:0]   async_data_slave_r_rptr_i
);

    // Full when the write pointer is one lap ahead: gray(wbin) equals the read
    // pointer with its two MSBs inverted.
    localparam logic [PtrW-1:0] FullMask = PtrW'(3) << (PtrW - 2);

    // Receive channels: binary read pointer, registered gray copy, synced wptr.
    logic [PtrW-1:0] aw_rbin, aw_wsync, aw_rgray_next;
    logic [PtrW-1:0] w_rbin,  w_wsync,  w_rgray_next;
    logic [PtrW-1:0] ar_rbin, ar_wsync, ar_rgray_next;
    logic            aw_valid, w_valid, ar_valid;

    // Transmit channels: binary write pointer and synced rptr.
    logic [PtrW-1:0] b_wbin, b_rsync, b_wgray_next;
    logic [PtrW-1:0] r_wbin, r_rsync, r_wgray_next;
    logic            b_ready, r_ready;

    axi_cdc_gray_ptr_sync #(.PtrWidth(PtrW), .SyncStages(SyncStages)) i_aw_sync (
        .clk(dst_clk_i), .rst_n(dst_rst_ni), .ptr_async(async_data_slave_aw_wptr_i),
        .ptr_bin(aw_rbin + PtrW'(1)), .ptr_synced(aw_wsync), .ptr_gray(aw_rgray_next)
    );
    axi_cdc_gray_ptr_sync #(.PtrWidth(PtrW), .SyncStages(SyncStages)) i_w_sync (
        .clk(dst_clk_i), .rst_n(dst_rst_ni), .ptr_async(async_data_slave_w_wptr_i),
        .ptr_bin(w_rbin + PtrW'(1)), .ptr_synced(w_wsync), .ptr_gray(w_rgray_next)
    );
    axi_cdc_gray_ptr_sync #(.PtrWidth(PtrW), .SyncStages(SyncStages)) i_ar_sync (
        .clk(dst_clk_i), .rst_n(dst_rst_ni), .ptr_async(async_data_slave_ar_wptr_i),
        .ptr_bin(ar_rbin + PtrW'(1)), .ptr_synced(ar_wsync), .ptr_gray(ar_rgray_next)
    );
    axi_cdc_gray_ptr_sync #(.PtrWidth(PtrW), .SyncStages(SyncStages)) i_b_sync (
        .clk(dst_clk_i), .rst_n(dst_rst_ni), .ptr_async(async_data_slave_b_rptr_i),
        .ptr_bin(b_wbin + PtrW'(1)), .ptr_synced(b_rsync), .ptr_gray(b_wgray_next)
    );
    axi_cdc_gray_ptr_sync #(.PtrWidth(PtrW), .SyncStages(SyncStages)) i_r_sync (
        .clk(dst_clk_i), .rst_n(dst_rst_ni), .ptr_async(async_data_slave_r_rptr_i),
        .ptr_bin(r_wbin + PtrW'(1)), .ptr_synced(r_rsync), .ptr_gray(r_wgray_next)
    );

    // The registered gray read pointer always equals gray(rbin), so empty is
    // a compare of two flop outputs only.
    assign aw_valid = (aw_wsync != async_data_slave_aw_rptr_o);
    assign w_valid  = (w_wsync  != async_data_slave_w_rptr_o);
    assign ar_valid = (ar_wsync != async_data_slave_ar_rptr_o);

    assign b_ready = (async_data_slave_b_wptr_o != (b_rsync ^ FullMask));
    assign r_ready = (async_data_slave_r_wptr_o != (r_rsync ^ FullMask));

    always_comb begin
        dst_req_o          = '0;
        dst_req_o.aw       = async_data_slave_aw_data_i[aw_rbin[LogDepth-1:0]];
        dst_req_o.aw_valid = aw_valid;
        dst_req_o.w        = async_data_slave_w_data_i[w_rbin[LogDepth-1:0]];
        dst_req_o.w_valid  = w_valid;
        dst_req_o.ar       = async_data_slave_ar_data_i[ar_rbin[LogDepth-1:0]];
        dst_req_o.ar_valid = ar_valid;
        dst_req_o.b_ready  = b_ready;
        dst_req_o.r_ready  = r_ready;
    end

    always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
        if (!dst_rst_ni) begin
            aw_rbin                    <= '0;
            w_rbin                     <= '0;
            ar_rbin                    <= '0;
            async_data_slave_aw_rptr_o <= '0;
            async_data_slave_w_rptr_o  <= '0;
            async_data_slave_ar_rptr_o <= '0;
        end else begin
            if (aw_valid && dst_resp_i.aw_ready) begin
                aw_rbin                    <= aw_rbin + PtrW'(1);
                async_data_slave_aw_rptr_o <= aw_rgray_next;
            end
            if (w_valid && dst_resp_i.w_ready) begin
                w_rbin                     <= w_rbin + PtrW'(1);
                async_data_slave_w_rptr_o  <= w_rgray_next;
            end
            if (ar_valid && dst_resp_i.ar_ready) begin
                ar_rbin                    <= ar_rbin + PtrW'(1);
                async_data_slave_ar_rptr_o <= ar_rgray_next;
            end
        end
    end

    // Entry write and pointer advance share one edge; the source only reads
    // an entry once the advanced pointer has crossed its synchronizer.
    always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
        if (!dst_rst_ni) begin
            b_wbin                    <= '0;
            r_wbin                    <= '0;
            async_data_slave_b_wptr_o <= '0;
            async_data_slave_r_wptr_o <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                async_data_slave_b_data_o[i] <= '0;
                async_data_slave_r_data_o[i] <= '0;
            end
        end else begin
            if (dst_resp_i.b_valid && b_ready) begin
                async_data_slave_b_data_o[b_wbin[LogDepth-1:0]] <= dst_resp_i.b;
                b_wbin                    <= b_wbin + PtrW'(1);
                async_data_slave_b_wptr_o <= b_wgray_next;
            end
            if (dst_resp_i.r_valid && r_ready) begin
                async_data_slave_r_data_o[r_wbin[LogDepth-1:0]] <= dst_resp_i.r;
                r_wbin                    <= r_wbin + PtrW'(1);
                async_data_slave_r_wptr_o <= r_wgray_next;
            end
        end
    end

endmodule

// File: tb/tb_axi_cdc_dst_gray.sv
// Scoreboard bench for axi_cdc_dst_gray with LogDepth=1, SyncStages=2.
module tb_axi_cdc_dst_gray;
    import axi_cdc_dst_gray_pkg::*;

    localparam int unsigned Depth = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_req_t   req;
    axi_resp_t  resp;
    aw_chan_t   aw_data [Depth];
    w_chan_t    w_data  [Depth];
    ar_chan_t   ar_data [Depth];
    b_chan_t    b_data  [Depth];
    r_chan_t    r_data  [Depth];
    logic [1:0] aw_wptr, w_wptr, ar_wptr, aw_rptr, w_rptr, ar_rptr;
    logic [1:0] b_wptr, r_wptr, b_rptr, r_rptr;

    int checks = 0;
    int errors = 0;
    logic [7:0] aw_q[$], w_q[$], ar_q[$], b_q[$], r_q[$];

    axi_cdc_dst_gray #(
        .LogDepth(1), .SyncStages(2),
        .aw_chan_t(aw_chan_t), .w_chan_t(w_chan_t), .b_chan_t(b_chan_t),
        .ar_chan_t(ar_chan_t), .r_chan_t(r_chan_t),
        .axi_req_t(axi_req_t), .axi_resp_t(axi_resp_t)
    ) dut (
        .dst_clk_i(clk), .dst_rst_ni(rst_n),
        .dst_req_o(req), .dst_resp_i(resp),
        .async_data_slave_aw_data_i(aw_data), .async_data_slave_aw_wptr_i(aw_wptr),
        .async_data_slave_aw_rptr_o(aw_rptr),
        .async_data_slave_w_data_i(w_data), .async_data_slave_w_wptr_i(w_wptr),
        .async_data_slave_w_rptr_o(w_rptr),
        .async_data_slave_ar_data_i(ar_data), .async_data_slave_ar_wptr_i(ar_wptr),
        .async_data_slave_ar_rptr_o(ar_rptr),
        .async_data_slave_b_data_o(b_data), .async_data_slave_b_wptr_o(b_wptr),
        .async_data_slave_b_rptr_i(b_rptr),
        .async_data_slave_r_data_o(r_data), .async_data_slave_r_wptr_o(r_wptr),
        .async_data_slave_r_rptr_i(r_rptr)
    );

    function automatic logic [1:0] g(input logic [1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_aw_valid"}, req.aw_valid, 0);
        chk({tag, "_w_valid"},  req.w_valid,  0);
        chk({tag, "_ar_valid"}, req.ar_valid, 0);
        chk({tag, "_b_ready"},  req.b_ready,  1);
        chk({tag, "_r_ready"},  req.r_ready,  1);
        chk({tag, "_aw_rptr"},  aw_rptr, 0);
        chk({tag, "_w_rptr"},   w_rptr,  0);
        chk({tag, "_ar_rptr"},  ar_rptr, 0);
        chk({tag, "_b_wptr"},   b_wptr,  0);
        chk({tag, "_r_wptr"},   r_wptr,  0);
        for (int i = 0; i < Depth; i++) begin
            chk({tag, "_b_data"}, b_data[i].id,   0);
            chk({tag, "_r_data"}, r_data[i].data, 0);
        end
    endtask

    // Receive monitor: read-pointer model advanced on observed handshakes,
    // payload popped from the scoreboard on each handshake.
    logic [1:0] aw_m, w_m, ar_m, ar_prev;
    always @(negedge clk) begin
        if (!rst_n) begin
            aw_m <= '0; w_m <= '0; ar_m <= '0; ar_prev <= '0;
        end else begin
            chk("aw_rptr_track", aw_rptr, g(aw_m));
            chk("w_rptr_track",  w_rptr,  g(w_m));
            chk("ar_rptr_track", ar_rptr, g(ar_m));
            if (ar_rptr != ar_prev) chk("ar_rptr_onebit", $countones(ar_rptr ^ ar_prev), 1);
            ar_prev <= ar_rptr;
            if (req.aw_valid && resp.aw_ready) begin
                if (aw_q.size() != 0) chk("aw_payload", req.aw.addr, aw_q.pop_front());
                else report_fail("aw_unexpected_pop");
                aw_m <= aw_m + 2'd1;
            end
            if (req.w_valid && resp.w_ready) begin
                if (w_q.size() != 0) chk("w_payload", req.w.data, w_q.pop_front());
                else report_fail("w_unexpected_pop");
                w_m <= w_m + 2'd1;
            end
            if (req.ar_valid && resp.ar_ready) begin
                if (ar_q.size() != 0) chk("ar_payload", req.ar.addr, ar_q.pop_front());
                else report_fail("ar_unexpected_pop");
                ar_m <= ar_m + 2'd1;
            end
        end
    end

    // Transmit monitor: on a handshake remember the target entry, compare the
    // stored data one cycle later.
    logic b_pend, r_pend, b_idx, r_idx;
    always @(negedge clk) begin
        if (!rst_n) begin
            b_pend <= 1'b0; r_pend <= 1'b0; b_idx <= 1'b0; r_idx <= 1'b0;
        end else begin
            if (b_pend) begin
                if (b_q.size() != 0) chk("b_stored", b_data[b_idx].id, b_q.pop_front());
                else report_fail("b_unexpected_write");
                b_pend <= 1'b0;
            end
            if (r_pend) begin
                if (r_q.size() != 0) chk("r_stored", r_data[r_idx].data, r_q.pop_front());
                else report_fail("r_unexpected_write");
                r_pend <= 1'b0;
            end
            if (resp.b_valid && req.b_ready) begin
                b_pend <= 1'b1;
                b_idx  <= b_wptr[1] ^ b_wptr[0];
            end
            if (resp.r_valid && req.r_ready) begin
                r_pend <= 1'b1;
                r_idx  <= r_wptr[1] ^ r_wptr[0];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ar_sb;
        int budget;
        resp = '0;
        aw_wptr = '0; w_wptr = '0; ar_wptr = '0; b_rptr = '0; r_rptr = '0;
        for (int i = 0; i < Depth; i++) begin
            aw_data[i] = '0; w_data[i] = '0; ar_data[i] = '0;
        end
        ar_sb = '0;

        tick(2);
        check_idle("in_reset");
        rst_n = 1'b1;
        tick();
        check_idle("after_reset");

        // AW: one entry, valid after two edges, pop advances rptr.
        aw_data[0].addr = 8'hA5;
        aw_q.push_back(8'hA5);
        aw_wptr = 2'b01;
        tick();
        chk("aw_valid_1edge", req.aw_valid, 0);
        tick();
        chk("aw_valid_2edge", req.aw_valid, 1);
        chk("aw_payload_direct", req.aw.addr, 8'hA5);
        resp.aw_ready = 1'b1;
        tick();
        resp.aw_ready = 1'b0;
        chk("aw_rptr_after_pop", aw_rptr, 2'b01);
        chk("aw_valid_after_pop", req.aw_valid, 0);

        // B: two pushes fill the FIFO; freeing one slot reopens after 2 edges.
        resp.b_valid = 1'b1;
        resp.b.id = 8'h11;
        b_q.push_back(8'h11);
        tick();
        chk("b_wptr_1", b_wptr, 2'b01);
        chk("b_ready_1", req.b_ready, 1);
        resp.b.id = 8'h22;
        b_q.push_back(8'h22);
        tick();
        resp.b_valid = 1'b0;
        chk("b_wptr_2", b_wptr, 2'b11);
        chk("b_ready_full", req.b_ready, 0);
        b_rptr = 2'b01;
        tick();
        chk("b_ready_1edge", req.b_ready, 0);
        tick();
        chk("b_ready_2edge", req.b_ready, 1);

        // AR: stream 8 beats, source refills as slots free up.
        resp.ar_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            budget = 0;
            while (g(ar_sb) == (ar_rptr ^ 2'b11) && budget < 50) begin
                tick();
                budget++;
            end
            if (budget >= 50) report_fail("ar_src_room_timeout");
            ar_data[ar_sb[0]].addr = 8'(8'h80 + k);
            ar_q.push_back(8'(8'h80 + k));
            ar_sb = ar_sb + 2'd1;
            ar_wptr = g(ar_sb);
            tick();
        end
        budget = 0;
        while (ar_rptr != ar_wptr && budget < 50) begin
            tick();
            budget++;
        end
        chk("ar_drained_rptr", ar_rptr, 2'b00);

        // AR backpressure: payload and rptr hold for 5 cycles, then one pop.
        resp.ar_ready = 1'b0;
        ar_data[ar_sb[0]].addr = 8'hC3;
        ar_q.push_back(8'hC3);
        ar_sb = ar_sb + 2'd1;
        ar_wptr = g(ar_sb);
        budget = 0;
        while (!req.ar_valid && budget < 20) begin
            tick();
            budget++;
        end
        chk("ar_valid_stall_start", req.ar_valid, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("ar_stall_payload", req.ar.addr, 8'hC3);
            chk("ar_stall_rptr", ar_rptr, 2'b00);
            chk("ar_stall_valid", req.ar_valid, 1);
        end
        resp.ar_ready = 1'b1;
        tick();
        resp.ar_ready = 1'b0;
        chk("ar_single_pop_rptr", ar_rptr, 2'b01);
        chk("ar_single_pop_valid", req.ar_valid, 0);

        // R full, W non-empty, then reset mid-cycle.
        resp.r_valid = 1'b1;
        resp.r.data = 8'h33;
        r_q.push_back(8'h33);
        tick();
        resp.r.data = 8'h44;
        r_q.push_back(8'h44);
        tick();
        resp.r_valid = 1'b0;
        chk("r_ready_full", req.r_ready, 0);
        chk("r_wptr_full", r_wptr, 2'b11);
        w_data[0].data = 8'h5A;
        w_wptr = 2'b01;
        tick(2);
        chk("w_valid_before_reset", req.w_valid, 1);
        chk("w_payload_before_reset", req.w.data, 8'h5A);

        #2;
        rst_n = 1'b0;
        aw_wptr = '0; w_wptr = '0; ar_wptr = '0; b_rptr = '0; r_rptr = '0;
        #1;
        check_idle("mid_reset");
        tick(2);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_reset_aw_valid", req.aw_valid, 0);
            chk("post_reset_w_valid",  req.w_valid,  0);
            chk("post_reset_ar_valid", req.ar_valid, 0);
        end
        check_idle("post_reset");

        chk("aw_q_left", aw_q.size(), 0);
        chk("w_q_left",  w_q.size(),  0);
        chk("ar_q_left", ar_q.size(), 0);
        chk("b_q_left",  b_q.size(),  0);
        chk("r_q_left",  r_q.size(),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_cdc_dst_gray.md
AXI_CDC_DST_GRAY -- requirements
Module: axi_cdc_dst_gray

Interface
REQ-001 SHALL have parameter LogDepth, default 1, FIFO depth per channel = 2**LogDepth (LogDepth >= 1).
REQ-002 SHALL have parameter SyncStages, default 2, number of synchronizer flops on each incoming async pointer (>= 2).
REQ-003 SHALL have type parameters aw_chan_t, w_chan_t, b_chan_t, ar_chan_t, r_chan_t, axi_req_t, axi_resp_t, each defaulting to logic.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: dst_clk_i  in  1  destination clock; dst_rst_ni  in  1  async active-low reset.
REQ-005 SHALL have dst_req_o  out  axi_req_t  synchronous AXI master request (aw/w/ar payload+valid, b_ready, r_ready).
REQ-006 SHALL have dst_resp_i  in  axi_resp_t  synchronous AXI response (aw/w/ar ready, b/r payload+valid).
REQ-007 SHALL have, for x in {aw,w,ar}: async_data_slave_x_data_i  in  [2**LogDepth] x_chan_t  source-owned FIFO storage; async_data_slave_x_wptr_i  in  LogDepth+1  gray write pointer; async_data_slave_x_rptr_o  out  LogDepth+1  gray read pointer.
REQ-008 SHALL have, for x in {b,r}: async_data_slave_x_data_o  out  [2**LogDepth] x_chan_t  locally owned FIFO storage; async_data_slave_x_wptr_o  out  LogDepth+1  gray write pointer; async_data_slave_x_rptr_i  in  LogDepth+1  gray read pointer.

Function
REQ-009 Receive channels (aw, w, ar) SHALL each hold a binary read pointer rbin (LogDepth+1 bits) and a registered gray copy driven on x_rptr_o.
REQ-010 Incoming x_wptr_i SHALL pass through SyncStages flops clocked by dst_clk_i before any use; no combinational path from any async input to valid/ready.
REQ-011 Receive empty SHALL be: synced wptr == gray(rbin); x_valid = !empty; x payload = x_data_i[rbin[LogDepth-1:0]].
REQ-012 On x_valid && x_ready, rbin SHALL increment modulo 2**(LogDepth+1) and x_rptr_o SHALL update on the same edge; single pop per cycle.
REQ-013 While x_valid && !x_ready, payload and x_rptr_o SHALL remain stable (AXI stability rule).
REQ-014 Transmit channels (b, r) SHALL each own 2**LogDepth registers of x_chan_t driven on x_data_o, a binary write pointer wbin, and a registered gray copy on x_wptr_o.
REQ-015 Transmit full SHALL be: gray(wbin) == synced x_rptr_i with its two MSBs inverted; x_ready = !full.
REQ-016 On x_valid && x_ready the payload SHALL be written to entry wbin[LogDepth-1:0] and wbin incremented on the same edge; the data register SHALL be stable before x_wptr_o advances (write and pointer in one edge; data never changes for an entry the pointer still exposes).
REQ-017 Only one gray pointer bit SHALL change per cycle on every *_ptr_o; wrap 2**(LogDepth+1)-1 -> 0 is a normal single-bit step.
REQ-018 Latency: source wptr change -> x_valid high after exactly SyncStages dst_clk_i edges; local pop -> x_rptr_o changes 1 edge after handshake.
REQ-019 Full throughput: one transfer per cycle per channel when not empty/full; all five channels independent.

Reset
REQ-020 On dst_rst_ni low, asynchronously: all pointers and synchronizer flops = 0; aw/w/ar valid = 0; b/r ready = 1; b/r storage = '0; all *_ptr_o = 0.
REQ-021 Reset asserted mid-transfer SHALL discard all in-flight entries; source half is required to be reset concurrently (documented integration rule, not checked).

Structure
REQ-022 Channel/req/resp typedefs SHALL come from the shared axi typedef macros; no new package constants.
REQ-023 One sub-module, axi_cdc_gray_ptr_sync, SHALL implement SyncStages-deep pointer synchronization plus bin<->gray conversion, instantiated once per channel.

Verification (LogDepth=1, SyncStages=2, ptr width 2)
REQ-024 Reset release: aw/w/ar_valid=0, b_ready=r_ready=1, all *_ptr_o=2'b00, b/r data_o=0.
REQ-025 aw_data_i[0]=0xA5 payload, aw_wptr_i 00->01 -> aw_valid=1 with payload 0xA5 on 2nd edge; aw_ready=1 -> aw_rptr_o=01 next edge, aw_valid=0.
REQ-026 Push two B beats, b_rptr_i held 00 -> b_wptr_o 01 then 11, b_ready=0 after 2nd push; b_rptr_i=01 -> b_ready=1 after 2 edges.
REQ-027 Stream 8 AR beats with ready=1 -> ar_rptr_o cycles 00,01,11,10,00,..., payload order preserved, one bit change per step.
REQ-028 ar_valid high, ar_ready low 5 cycles -> payload and ar_rptr_o unchanged; then ready=1 -> single pop.
REQ-029 Assert dst_rst_ni low with r FIFO full and w non-empty -> outputs return to REQ-024 values immediately, no spurious valid after release.
